// File: rtl/aq_djpeg_ycbcr2rgb.sv
// aq_djpeg_ycbcr2rgb
// Reads one 16x16 MCU from the YCbCr buffer in raster order and converts each
// pixel to 8-bit RGB in a 3-stage pipeline. The pipeline stalls as a whole
// when an output pixel is held back by the downstream sink.
//
// state | meaning
// IDLE  | waiting for the buffer to report a complete MCU
// RUN   | issuing one read per enabled cycle, pixel (0,0) .. (15,15)
// NEXT  | one-cycle bank release strobe after the final read
module aq_djpeg_ycbcr2rgb (
  input  logic       clk,
  input  logic       rst,
  input  logic       DataInit,
  input  logic [2:0] JpegComp,
  input  logic       DataOutEnable,
  output logic [7:0] DataOutAddressY,
  output logic [7:0] DataOutAddressCbCr,
  output logic       DataOutRead,
  output logic       DataOutReadNext,
  input  logic [8:0] DataOutY,
  input  logic [8:0] DataOutCb,
  input  logic [8:0] DataOutCr,
  output logic       PixelValid,
  input  logic       PixelReady,
  output logic [7:0] PixelR,
  output logic [7:0] PixelG,
  output logic [7:0] PixelB,
  output logic [3:0] PixelX,
  output logic [3:0] PixelY,
  output logic       PixelLast
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, NEXT = 2'd2} stateT;

  stateT state, stateNext;
  logic en;
  logic [7:0] cnt;

  logic v1, v2;
  logic [7:0] pos1, pos2;
  logic last1, last2;

  logic [7:0] y8, cb8, cr8;
  logic signed [8:0] cb, cr;
  logic signed [18:0] cbExt, crExt;
  logic signed [18:0] yr, pr, pgb, pgr, pb;
  logic signed [20:0] sumR, sumG, sumB;

  // Clamp a shifted sum into the 0..255 pixel range.
  function automatic logic [7:0] sat8(input logic signed [20:0] v);
    logic [7:0] res;
    if (v < 21'sd0) res = 8'd0;
    else if (v > 21'sd255) res = 8'hFF;
    else res = v[7:0];
    return res;
  endfunction

  assign en = !PixelValid | PixelReady;

  // Y buffer is organised as four 8x8 blocks; Cb/Cr are stored plain raster.
  assign DataOutAddressY    = {cnt[7], cnt[3], cnt[6:4], cnt[2:0]};
  assign DataOutAddressCbCr = cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else if (DataInit) state <= IDLE;
    else state <= stateNext;
  end

  // Next-state and read/release strobes; an MCU is committed once RUN starts.
  always_comb begin
    stateNext       = state;
    DataOutRead     = 1'b0;
    DataOutReadNext = 1'b0;
    case (state)
      IDLE: if (DataOutEnable) stateNext = RUN;
      RUN: begin
        DataOutRead = en;
        if (en && cnt == 8'hFF) stateNext = NEXT;
      end
      NEXT: begin
        DataOutReadNext = 1'b1;
        stateNext       = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Pixel counter {Y,X}, advanced by every issued read; wraps to 0 after (15,15).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 8'd0;
    else if (DataInit) cnt <= 8'd0;
    else if (DataOutRead) cnt <= cnt + 8'd1;
  end

  // Stage 1: saturate the 9-bit buffer data and centre the chroma.
  always_comb begin
    y8    = DataOutY[8]  ? 8'hFF : DataOutY[7:0];
    cb8   = DataOutCb[8] ? 8'hFF : DataOutCb[7:0];
    cr8   = DataOutCr[8] ? 8'hFF : DataOutCr[7:0];
    if (JpegComp == 3'd1) begin
      cb8 = 8'd128;
      cr8 = 8'd128;
    end
    cb    = $signed({1'b0, cb8}) - 9'sd128;
    cr    = $signed({1'b0, cr8}) - 9'sd128;
    cbExt = {{10{cb[8]}}, cb};
    crExt = {{10{cr[8]}}, cr};
    sumR  = {{2{yr[18]}}, yr} + {{2{pr[18]}}, pr} + 21'sd128;
    sumG  = {{2{yr[18]}}, yr} - {{2{pgb[18]}}, pgb} - {{2{pgr[18]}}, pgr} + 21'sd128;
    sumB  = {{2{yr[18]}}, yr} + {{2{pb[18]}}, pb} + 21'sd128;
  end

  // Pipeline stages 2 and 3 with their valid/position tags; frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; PixelValid <= 1'b0;
      pos1 <= 8'd0; pos2 <= 8'd0;
      last1 <= 1'b0; last2 <= 1'b0; PixelLast <= 1'b0;
      yr <= '0; pr <= '0; pgb <= '0; pgr <= '0; pb <= '0;
      PixelR <= 8'd0; PixelG <= 8'd0; PixelB <= 8'd0;
      PixelX <= 4'd0; PixelY <= 4'd0;
    end else if (DataInit) begin
      v1 <= 1'b0; v2 <= 1'b0; PixelValid <= 1'b0;
      last1 <= 1'b0; last2 <= 1'b0; PixelLast <= 1'b0;
    end else if (en) begin
      v1    <= DataOutRead;
      pos1  <= cnt;
      last1 <= DataOutRead && (cnt == 8'hFF);

      v2    <= v1;
      pos2  <= pos1;
      last2 <= last1;
      yr    <= {3'b000, y8, 8'h00};
      pr    <= crExt * 19'sd359;
      pgb   <= cbExt * 19'sd88;
      pgr   <= crExt * 19'sd183;
      pb    <= cbExt * 19'sd454;

      PixelValid <= v2;
      PixelX     <= pos2[3:0];
      PixelY     <= pos2[7:4];
      PixelLast  <= last2;
      PixelR     <= sat8(sumR >>> 8);
      PixelG     <= sat8(sumG >>> 8);
      PixelB     <= sat8(sumB >>> 8);
    end
  end

endmodule

// File: tb/tb_aq_djpeg_ycbcr2rgb.sv
// Testbench for aq_djpeg_ycbcr2rgb: directed colour vectors, timing,
// back-to-back MCUs with random backpressure, and mid-MCU abort.
module tb_aq_djpeg_ycbcr2rgb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       DataInit = 1'b0;
  logic [2:0] JpegComp = 3'd3;
  logic       DataOutEnable = 1'b0;
  logic [7:0] DataOutAddressY, DataOutAddressCbCr;
  logic       DataOutRead, DataOutReadNext;
  logic [8:0] DataOutY = '0, DataOutCb = '0, DataOutCr = '0;
  logic       PixelValid;
  logic       PixelReady = 1'b1;
  logic [7:0] PixelR, PixelG, PixelB;
  logic [3:0] PixelX, PixelY;
  logic       PixelLast;

  aq_djpeg_ycbcr2rgb dut (
    .clk(clk), .rst(rst), .DataInit(DataInit), .JpegComp(JpegComp),
    .DataOutEnable(DataOutEnable),
    .DataOutAddressY(DataOutAddressY), .DataOutAddressCbCr(DataOutAddressCbCr),
    .DataOutRead(DataOutRead), .DataOutReadNext(DataOutReadNext),
    .DataOutY(DataOutY), .DataOutCb(DataOutCb), .DataOutCr(DataOutCr),
    .PixelValid(PixelValid), .PixelReady(PixelReady),
    .PixelR(PixelR), .PixelG(PixelG), .PixelB(PixelB),
    .PixelX(PixelX), .PixelY(PixelY), .PixelLast(PixelLast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] jc;
    logic [8:0] y, cb, cr;
    logic [7:0] r, g, b;
  } vecT;

  typedef struct {
    logic [7:0] r, g, b;
    logic [3:0] x, y;
    logic       last;
  } pixT;

  vecT vecs[8];
  pixT q[$];
  logic [7:0] addrLog[$];

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int readCount, nextPulses, firstReadCycle, firstValidCycle, lastReadCycle, nextCycle;
  int addrErr, stabErr, stallCount, enCycle;
  int curBank = 0;
  int readyMode = 0;
  logic readyForce = 1'b1;
  logic patMode = 1'b0;
  logic [8:0] cY = '0, cCb = '0, cCr = '0;
  logic prevStall = 1'b0;
  logic [36:0] prevOut = '0;
  logic [7:0] iy;

  // Buffer data generators for the pattern runs; values above 255 exercise saturation.
  function automatic logic [8:0] fY(input int b, input int i);
    int v; v = (i * 37 + b * 101) % 512; return v[8:0];
  endfunction
  function automatic logic [8:0] fCb(input int b, input int i);
    int v; v = (i * 53 + b * 29 + 11) % 512; return v[8:0];
  endfunction
  function automatic logic [8:0] fCr(input int b, input int i);
    int v; v = (i * 71 + b * 13 + 200) % 512; return v[8:0];
  endfunction

  function automatic int clip(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Integer reference of the colour equations.
  function automatic logic [23:0] refRgb(input logic [2:0] jc, input logic [8:0] y,
                                         input logic [8:0] cbIn, input logic [8:0] crIn);
    int yy, c, r, vr, vg, vb;
    logic [7:0] r8, g8, b8;
    yy = y[8] ? 255 : int'(y[7:0]);
    c  = (jc == 3'd1) ? 0 : ((cbIn[8] ? 255 : int'(cbIn[7:0])) - 128);
    r  = (jc == 3'd1) ? 0 : ((crIn[8] ? 255 : int'(crIn[7:0])) - 128);
    vr = (yy * 256 + 359 * r + 128) >>> 8;
    vg = (yy * 256 - 88 * c - 183 * r + 128) >>> 8;
    vb = (yy * 256 + 454 * c + 128) >>> 8;
    r8 = 8'(clip(vr)); g8 = 8'(clip(vg)); b8 = 8'(clip(vb));
    return {r8, g8, b8};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clearStats();
    q.delete(); addrLog.delete();
    readCount = 0; nextPulses = 0; firstReadCycle = -1; firstValidCycle = -1;
    lastReadCycle = -1; nextCycle = -1; addrErr = 0; stabErr = 0; stallCount = 0;
  endtask

  // Runs one MCU to completion and drains the pipeline.
  task automatic runMcu();
    int n;
    clearStats();
    DataOutEnable = 1'b1;
    enCycle = cycle;
    n = 0;
    while (nextPulses == 0 && n < 3000) begin tick(); n++; end
    DataOutEnable = 1'b0;
    n = 0;
    while (q.size() < 256 && n < 3000) begin tick(); n++; end
    repeat (5) tick();
  endtask

  // Compares the captured stream against the reference for nMcu consecutive banks.
  task automatic cmpStream(input string name, input int startB, input int nMcu);
    int bad;
    logic [23:0] e;
    bad = 0;
    for (int k = 0; k < q.size(); k++) begin
      int b, i;
      b = startB + k / 256;
      i = k % 256;
      e = refRgb(3'd3, fY(b, i), fCb(b, i), fCr(b, i));
      if ({q[k].r, q[k].g, q[k].b} !== e || q[k].x !== 4'(i % 16) ||
          q[k].y !== 4'(i / 16) || q[k].last !== (i == 255)) bad++;
    end
    check({name, " count"}, q.size(), nMcu * 256);
    check({name, " bad pixels"}, bad, 0);
  endtask

  always @(posedge clk) cycle++;

  // Buffer model: registered read data, held while no read is issued.
  always @(posedge clk) begin
    if (DataOutRead) begin
      iy = {DataOutAddressY[7], DataOutAddressY[5:3], DataOutAddressY[6], DataOutAddressY[2:0]};
      DataOutY  <= patMode ? fY(curBank, int'(iy)) : cY;
      DataOutCb <= patMode ? fCb(curBank, int'(DataOutAddressCbCr)) : cCb;
      DataOutCr <= patMode ? fCr(curBank, int'(DataOutAddressCbCr)) : cCr;
    end
    if (DataOutReadNext) curBank <= curBank + 1;
  end

  // Downstream ready driver.
  initial forever begin
    @(posedge clk); #1;
    if (readyMode == 0) PixelReady = 1'b1;
    else if (readyMode == 1) PixelReady = ($urandom_range(0, 99) < 30);
    else PixelReady = readyForce;
  end

  // Monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (DataOutRead) begin
        if (readCount == 0) firstReadCycle = cycle;
        readCount++;
        lastReadCycle = cycle;
        addrLog.push_back(DataOutAddressY);
        if ({DataOutAddressY[7], DataOutAddressY[5:3], DataOutAddressY[6], DataOutAddressY[2:0]}
            != DataOutAddressCbCr) addrErr++;
      end
      if (DataOutReadNext) begin nextPulses++; nextCycle = cycle; end
      if (PixelValid && firstValidCycle < 0) firstValidCycle = cycle;
      if (PixelValid && PixelReady) begin
        pixT p;
        p.r = PixelR; p.g = PixelG; p.b = PixelB;
        p.x = PixelX; p.y = PixelY; p.last = PixelLast;
        q.push_back(p);
      end
      if (prevStall && !DataInit &&
          (!PixelValid || {PixelR, PixelG, PixelB, PixelX, PixelY, PixelLast} != prevOut))
        stabErr++;
      if (PixelValid && !PixelReady) stallCount++;
      prevStall = PixelValid && !PixelReady && !DataInit;
      prevOut   = {PixelR, PixelG, PixelB, PixelX, PixelY, PixelLast};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] expAddr[9];
    int bad, n, startBank;
    logic [23:0] first, e;

    vecs[0] = '{jc: 3'd3, y: 9'd128,   cb: 9'd128, cr: 9'd128, r: 8'd128, g: 8'd128, b: 8'd128};
    vecs[1] = '{jc: 3'd3, y: 9'd255,   cb: 9'd128, cr: 9'd255, r: 8'd255, g: 8'd164, b: 8'd255};
    vecs[2] = '{jc: 3'd3, y: 9'd0,     cb: 9'd255, cr: 9'd128, r: 8'd0,   g: 8'd0,   b: 8'd225};
    vecs[3] = '{jc: 3'd1, y: 9'd200,   cb: 9'd0,   cr: 9'd0,   r: 8'd200, g: 8'd200, b: 8'd200};
    vecs[4] = '{jc: 3'd1, y: 9'h1FF,   cb: 9'd0,   cr: 9'd0,   r: 8'd255, g: 8'd255, b: 8'd255};
    vecs[5] = '{jc: 3'd3, y: 9'h100,   cb: 9'd128, cr: 9'd128, r: 8'd255, g: 8'd255, b: 8'd255};
    vecs[6] = '{jc: 3'd3, y: 9'd128,   cb: 9'd0,   cr: 9'd128, r: 8'd128, g: 8'd172, b: 8'd0};
    vecs[7] = '{jc: 3'd5, y: 9'd128,   cb: 9'd128, cr: 9'd0,   r: 8'd0,   g: 8'd220, b: 8'd128};
    expAddr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h40};

    clearStats();
    repeat (3) @(negedge clk);
    check("reset outputs",
          {DataOutRead, DataOutReadNext, PixelValid, PixelLast, DataOutAddressY,
           DataOutAddressCbCr, PixelR, PixelG, PixelB, PixelX, PixelY}, 64'd0);
    #1 rst = 1'b0;

    repeat (10) tick();
    check("no read while disabled", readCount, 0);

    // Table-driven colour vectors, one full MCU each at full throughput.
    patMode = 1'b0; readyMode = 0;
    for (int k = 0; k < 8; k++) begin
      JpegComp = vecs[k].jc;
      cY = vecs[k].y; cCb = vecs[k].cb; cCr = vecs[k].cr;
      runMcu();
      e = {vecs[k].r, vecs[k].g, vecs[k].b};
      bad = 0;
      for (int i = 0; i < q.size(); i++)
        if ({q[i].r, q[i].g, q[i].b} !== e || q[i].x !== 4'(i % 16) ||
            q[i].y !== 4'(i / 16) || q[i].last !== (i == 255)) bad++;
      first = (q.size() > 0) ? {q[0].r, q[0].g, q[0].b} : 24'd0;
      check($sformatf("vec%0d count", k), q.size(), 256);
      check($sformatf("vec%0d rgb", k), first, e);
      check($sformatf("vec%0d bad pixels", k), bad, 0);
      if (k == 0) begin
        check("enable to first read", firstReadCycle - enCycle, 1);
        check("read to valid latency", firstValidCycle - firstReadCycle, 3);
        check("readnext after last read", nextCycle - lastReadCycle, 1);
        check("readnext pulses", nextPulses, 1);
        check("read count", readCount, 256);
        check("address encoding", addrErr, 0);
        for (int j = 0; j < 9; j++)
          check($sformatf("address seq %0d", j), (addrLog.size() > j) ? addrLog[j] : 8'hXX, expAddr[j]);
      end
    end

    // Four back-to-back MCUs with random backpressure.
    JpegComp = 3'd3; patMode = 1'b1; readyMode = 1;
    clearStats();
    startBank = curBank;
    DataOutEnable = 1'b1;
    n = 0;
    while (nextPulses < 4 && n < 20000) begin tick(); n++; end
    DataOutEnable = 1'b0;
    n = 0;
    while (q.size() < 1024 && n < 20000) begin tick(); n++; end
    repeat (20) tick();
    cmpStream("stream4", startBank, 4);
    check("stream4 stable while stalled", stabErr, 0);
    check("stream4 readnext pulses", nextPulses, 4);
    check("stream4 stalls seen", stallCount > 0, 1);

    // Abort in the middle of an MCU while the output is stalled.
    readyMode = 0;
    clearStats();
    DataOutEnable = 1'b1;
    n = 0;
    while (q.size() < 100 && n < 2000) begin tick(); n++; end
    readyForce = 1'b0; readyMode = 2;
    n = 0;
    while (!(PixelValid && !PixelReady) && n < 50) begin tick(); n++; end
    check("abort stall active", PixelValid && !PixelReady, 1);
    DataOutEnable = 1'b0;
    DataInit = 1'b1;
    tick();
    check("abort valid cleared", PixelValid, 0);
    check("abort no read", DataOutRead, 0);
    DataInit = 1'b0;
    readyForce = 1'b1; readyMode = 0;
    repeat (300) tick();
    check("abort no readnext", nextPulses, 0);

    // Next MCU after the abort starts again from pixel (0,0).
    startBank = curBank;
    runMcu();
    check("restart first address", (addrLog.size() > 0) ? addrLog[0] : 8'hXX, 8'h00);
    check("restart read count", readCount, 256);
    check("restart readnext pulses", nextPulses, 1);
    cmpStream("restart", startBank, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aq_djpeg_ycbcr2rgb.md
# aq_djpeg_ycbcr2rgb

Colour-conversion stage directly downstream of the YCbCr MCU buffer in the JPEG decoder. It waits for a filled MCU bank, reads the 16x16 MCU pixel by pixel, converts YCbCr to 8-bit RGB with a 3-stage stallable pipeline, and presents pixels on a valid/ready stream. After it has issued the last read of the MCU it pulses the release strobe, which frees the bank.

## Interface
Parameters:
- None.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- DataInit  in  1  synchronous abort/restart; same effect as reset on state, counters and valid bits
- JpegComp  in  3  3 = colour 4:2:0, 1 = grayscale (Cb/Cr forced to 128); other values treated as 3
- DataOutEnable  in  1  buffer holds at least one complete MCU
- DataOutAddressY  out  8  {Y[3],X[3],Y[2:0],X[2:0]} of the current pixel
- DataOutAddressCbCr  out  8  {Y[3:0],X[3:0]} of the current pixel
- DataOutRead  out  1  read strobe; buffer data is valid the cycle after and held while low
- DataOutReadNext  out  1  one-cycle bank release pulse
- DataOutY / DataOutCb / DataOutCr  in  9  buffer read data, unsigned; bit8 set means saturate to 255
- PixelValid  out  1  output pixel valid
- PixelReady  in  1  downstream accept
- PixelR / PixelG / PixelB  out  8  converted pixel
- PixelX / PixelY  out  4  pixel position within the MCU
- PixelLast  out  1  high with pixel (15,15)

## Operation
- Pipeline enable: en = !PixelValid | PixelReady. All stage registers and the address counter advance only when en = 1.
- FSM states:
  - IDLE: enters RUN when DataOutEnable = 1.
  - RUN: while en = 1, assert DataOutRead and increment the 8-bit counter {Y,X} raster-wise (X fastest). When the read of (15,15) is issued, go to NEXT.
  - NEXT: DataOutReadNext = 1 for exactly one cycle, then IDLE.
- IDLE samples DataOutEnable the cycle after NEXT, so the buffer has already updated its bank pointer.
- DataOutRead = (state == RUN) & en. The addresses are driven from the counter combinationally in every state.
- Stage valid bits:
  - v1 is set on an issued read.
  - v2 and v3 (v3 = PixelValid) shift when en = 1.
  - PixelX/PixelY/PixelLast travel with their data.
- Stage 1 (buffer register output):
  - Clamp each 9-bit input to 8 bits: bit8 ? 255 : [7:0].
  - If JpegComp == 1, Cb = Cr = 128.
  - Form cb = Cb-128 and cr = Cr-128, signed 9-bit.
- Stage 2 registers (signed 19-bit):
  - yr = Y<<8
  - pr = 359*cr
  - pgb = 88*cb
  - pgr = 183*cr
  - pb = 454*cb
- Stage 3 registers:
  - R = sat((yr + pr + 128) >>> 8)
  - G = sat((yr - pgb - pgr + 128) >>> 8)
  - B = sat((yr + pb + 128) >>> 8)
  - sat() clamps to 0..255; >>> is arithmetic.
- A new MCU read may start while pixels of the previous MCU are still in the pipeline; there is no bubble requirement.
- DataInit or rst at any time:
  - Return to IDLE; clear the counter and v1..v3.
  - No DataOutReadNext pulse is issued for the aborted MCU.

## Timing
- Reset values:
  - DataOutRead, DataOutReadNext, PixelValid, PixelLast = 0.
  - Address outputs = 0.
  - PixelR/G/B/X/Y = 0.
  - State = IDLE.
- Latency: a read issued in cycle t gives PixelValid in cycle t+3 when there is no stall.
- Throughput: 1 pixel/clock; one MCU takes 256 cycles plus 2 overhead cycles (NEXT, IDLE).
- Stall: while PixelValid & !PixelReady:
  - DataOutRead = 0 and no register changes.
  - Output data is held stable (AXI-style: valid is never dropped without ready).
- DataOutReadNext is asserted 1 cycle after the final DataOutRead. It is never asserted twice per MCU.
- If DataOutEnable drops during RUN, it is ignored; the MCU is committed once started.

## Test plan
- Single MCU, all pixels Y=Cb=Cr=128, PixelReady=1 -> 256 pixels of (128,128,128); PixelLast only on (15,15); one DataOutReadNext pulse 1 cycle after the last read; first PixelValid 3 cycles after the first DataOutRead.
- Y=255, Cb=128, Cr=255 -> (255,164,255). Y=0, Cb=255, Cr=128 -> (0,0,225).
- Grayscale (JpegComp=1), Y=200, Cb=Cr=0 -> (200,200,200). Y=9'h1FF -> (255,255,255).
- Random PixelReady at 30% duty over 4 back-to-back MCUs -> pixel stream matches the reference model in raster order; the data never changes while valid & !ready; exactly 4 DataOutReadNext pulses.
- DataOutEnable=0 -> no DataOutRead. DataOutEnable rises -> the first read occurs the next cycle, and address sequence 0x00,0x01,...,0x07,0x40,... matches the {Y3,X3,Y2:0,X2:0} encoding.
- DataInit asserted at pixel 100, with a stall active -> PixelValid=0 the next cycle, no DataOutReadNext pulse, and the next MCU restarts at address 0.
